// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller:
// FSM state codes, operand-forward select codes and the default flush length.
`ifndef PIPELINE_CTRL_PKG_SV
`define PIPELINE_CTRL_PKG_SV

package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HSTALL = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_MWAIT  = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam int FLUSH_CYCLES_DEFAULT = 2;

    // The memory stage holds the younger result, so it wins over writeback.
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

`endif

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational source/destination comparison for the pipeline controller.
// Optional feature macro: PIPELINE_CTRL_FORWARD_EN (forwarding paths present,
// only load-use in execute is a hazard). Default build: every in-flight
// writer matching a source register is a hazard and forwarding is off.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int AWIDTH = 5
) (
    input  logic [AWIDTH-1:0] rs1_addr,
    input  logic [AWIDTH-1:0] rs2_addr,
    input  logic [AWIDTH-1:0] ex_rd_addr,
    input  logic              ex_rd_we,
    input  logic              ex_is_load,
    input  logic [AWIDTH-1:0] mem_rd_addr,
    input  logic              mem_rd_we,
    input  logic [AWIDTH-1:0] wb_rd_addr,
    input  logic              wb_rd_we,
    output logic              hazard,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic addr_match(input logic [AWIDTH-1:0] src,
                                        input logic [AWIDTH-1:0] dst,
                                        input logic              we);
        return we && (dst != {AWIDTH{1'b0}}) && (src == dst);
    endfunction

    logic ex_a_s, ex_b_s, mem_a_s, mem_b_s, wb_a_s, wb_b_s;

    // Per-stage, per-operand match flags.
    always_comb begin
        ex_a_s  = addr_match(rs1_addr, ex_rd_addr,  ex_rd_we);
        ex_b_s  = addr_match(rs2_addr, ex_rd_addr,  ex_rd_we);
        mem_a_s = addr_match(rs1_addr, mem_rd_addr, mem_rd_we);
        mem_b_s = addr_match(rs2_addr, mem_rd_addr, mem_rd_we);
        wb_a_s  = addr_match(rs1_addr, wb_rd_addr,  wb_rd_we);
        wb_b_s  = addr_match(rs2_addr, wb_rd_addr,  wb_rd_we);
    end

`ifdef PIPELINE_CTRL_FORWARD_EN
    // Only a load in execute cannot be bypassed; everything else is forwarded.
    always_comb begin
        hazard = ex_is_load && (ex_a_s || ex_b_s);
        fwd_a  = fwd_select(mem_a_s, wb_a_s);
        fwd_b  = fwd_select(mem_b_s, wb_b_s);
    end
`else
    logic unused_is_load_s;
    assign unused_is_load_s = ex_is_load;

    // Without bypass paths any pending writer of a source register must stall decode.
    always_comb begin
        hazard = ex_a_s || ex_b_s || mem_a_s || mem_b_s || wb_a_s || wb_b_s;
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
    end
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/forward controller (RUN / HSTALL / FLUSH / MWAIT FSM).
// Optional feature macro: PIPELINE_CTRL_FORWARD_EN (see hazard_detect).
// Outputs are combinational from the current state and inputs.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int AWIDTH       = 5,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic              pc_clk,
    input  logic              pc_rst,
    input  logic              pc_i_ce,
    input  logic [AWIDTH-1:0] pc_i_rs1_addr,
    input  logic [AWIDTH-1:0] pc_i_rs2_addr,
    input  logic [AWIDTH-1:0] pc_i_ex_rd_addr,
    input  logic              pc_i_ex_rd_we,
    input  logic              pc_i_ex_is_load,
    input  logic [AWIDTH-1:0] pc_i_mem_rd_addr,
    input  logic              pc_i_mem_rd_we,
    input  logic [AWIDTH-1:0] pc_i_wb_rd_addr,
    input  logic              pc_i_wb_rd_we,
    input  logic              pc_i_change_pc,
    input  logic              pc_i_mem_busy,
    output logic              pc_o_stall_fd,
    output logic              pc_o_stall_all,
    output logic              pc_o_flush_fd,
    output logic              pc_o_flush_ex,
    output logic [1:0]        pc_o_fwd_a,
    output logic [1:0]        pc_o_fwd_b,
    output logic [1:0]        pc_o_state
);

    // The change_pc cycle itself flushes, so the FLUSH state covers the rest.
    // After a memory wait the redirect cycle is long gone: flush in full.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] FLUSH_FULL = 3'(FLUSH_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;

    logic       hazard_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    hazard_detect #(.AWIDTH(AWIDTH)) u_hazard (
        .rs1_addr    (pc_i_rs1_addr),
        .rs2_addr    (pc_i_rs2_addr),
        .ex_rd_addr  (pc_i_ex_rd_addr),
        .ex_rd_we    (pc_i_ex_rd_we),
        .ex_is_load  (pc_i_ex_is_load),
        .mem_rd_addr (pc_i_mem_rd_addr),
        .mem_rd_we   (pc_i_mem_rd_we),
        .wb_rd_addr  (pc_i_wb_rd_addr),
        .wb_rd_we    (pc_i_wb_rd_we),
        .hazard      (hazard_s),
        .fwd_a       (fwd_a_s),
        .fwd_b       (fwd_b_s)
    );

    // State, flush counter and pending-redirect flag registers.
    always_ff @(posedge pc_clk) begin
        if (pc_rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state and output decode; priority is mem_busy > change_pc > hazard.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        pc_o_stall_fd  = 1'b0;
        pc_o_stall_all = 1'b0;
        pc_o_flush_fd  = 1'b0;
        pc_o_flush_ex  = 1'b0;
        pc_o_fwd_a     = FWD_RF;
        pc_o_fwd_b     = FWD_RF;
        pc_o_state     = state_q;

        if (pc_rst) begin
            pc_o_flush_fd = 1'b1;
            pc_o_flush_ex = 1'b1;
            pc_o_state    = ST_RUN;
        end else if (!pc_i_ce) begin
            pc_o_stall_all = 1'b1;
        end else begin
            pc_o_fwd_a = fwd_a_s;
            pc_o_fwd_b = fwd_b_s;
            case (state_q)
                ST_RUN, ST_HSTALL: begin
                    if (pc_i_mem_busy) begin
                        // Remember a redirect that collides with the memory wait.
                        state_d = ST_MWAIT;
                        pend_d  = pc_i_change_pc;
                    end else if (pc_i_change_pc) begin
                        pc_o_flush_fd = 1'b1;
                        pc_o_flush_ex = 1'b1;
                        cnt_d         = FLUSH_LOAD;
                        state_d       = (FLUSH_LOAD == 3'd0) ? ST_RUN : ST_FLUSH;
                    end else if (hazard_s) begin
                        pc_o_stall_fd = 1'b1;
                        pc_o_flush_ex = 1'b1;
                        state_d       = ST_HSTALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    pc_o_flush_fd = 1'b1;
                    pc_o_flush_ex = 1'b1;
                    if (pc_i_mem_busy) begin
                        state_d = ST_MWAIT;
                        pend_d  = 1'b1;
                    end else if (pc_i_change_pc) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = (FLUSH_LOAD == 3'd0) ? ST_RUN : ST_FLUSH;
                    end else if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_MWAIT: begin
                    pc_o_stall_all = 1'b1;
                    if (pc_i_mem_busy) begin
                        pend_d = pend_q | pc_i_change_pc;
                    end else if (pend_q || pc_i_change_pc) begin
                        pend_d  = 1'b0;
                        cnt_d   = FLUSH_FULL;
                        state_d = ST_FLUSH;
                    end else begin
                        pend_d  = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// hazard sequences and randomized stimulus against a behavioural model.
module tb_pipeline_ctrl;

    localparam int FC = 2;

    typedef struct {
        logic       rst, ce, chg, busy;
        logic [4:0] rs1, rs2, ex_rd;
        logic       ex_we, ex_ld;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic       sfd, sall, ffd, fex;
        logic [1:0] fa, fb, st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, ce, chg, busy;
    logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_we, ex_ld, mem_we, wb_we;
    logic       o_sfd, o_sall, o_ffd, o_fex;
    logic [1:0] o_fa, o_fb, o_st;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: mode 0 run, 1 hazard stall, 2 flush, 3 memory wait.
    int m_mode = 0;
    int m_left = 0;   // flush cycles still owed, counting the current one
    bit m_pend = 1'b0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.AWIDTH(5), .FLUSH_CYCLES(FC)) dut (
        .pc_clk          (clk),
        .pc_rst          (rst),
        .pc_i_ce         (ce),
        .pc_i_rs1_addr   (rs1),
        .pc_i_rs2_addr   (rs2),
        .pc_i_ex_rd_addr (ex_rd),
        .pc_i_ex_rd_we   (ex_we),
        .pc_i_ex_is_load (ex_ld),
        .pc_i_mem_rd_addr(mem_rd),
        .pc_i_mem_rd_we  (mem_we),
        .pc_i_wb_rd_addr (wb_rd),
        .pc_i_wb_rd_we   (wb_we),
        .pc_i_change_pc  (chg),
        .pc_i_mem_busy   (busy),
        .pc_o_stall_fd   (o_sfd),
        .pc_o_stall_all  (o_sall),
        .pc_o_flush_fd   (o_ffd),
        .pc_o_flush_ex   (o_fex),
        .pc_o_fwd_a      (o_fa),
        .pc_o_fwd_b      (o_fb),
        .pc_o_state      (o_st)
    );

    function automatic vec_t v_ctl(bit r, bit e, bit c, bit b,
                                   bit sfd, bit sall, bit ffd, bit fex, bit [1:0] st);
        vec_t v;
        v.rst = r; v.ce = e; v.chg = c; v.busy = b;
        v.rs1 = 5'd0; v.rs2 = 5'd0; v.ex_rd = 5'd0; v.ex_we = 1'b0; v.ex_ld = 1'b0;
        v.mem_rd = 5'd0; v.mem_we = 1'b0; v.wb_rd = 5'd0; v.wb_we = 1'b0;
        v.sfd = sfd; v.sall = sall; v.ffd = ffd; v.fex = fex;
        v.fa = 2'd0; v.fb = 2'd0; v.st = st;
        return v;
    endfunction

    function automatic bit hit(logic [4:0] s, logic [4:0] d, logic we);
        return we && (d != 5'd0) && (s == d);
    endfunction

    function automatic logic [1:0] fsel(bit m, bit w);
        return m ? 2'd1 : (w ? 2'd2 : 2'd0);
    endfunction

    // Reference model: fills in expected outputs and advances its own state.
    task automatic model(inout vec_t v);
        bit haz;
        v.sfd = 1'b0; v.sall = 1'b0; v.ffd = 1'b0; v.fex = 1'b0;
        v.fa = 2'd0; v.fb = 2'd0; v.st = 2'(m_mode);
        if (v.rst) begin
            v.ffd = 1'b1; v.fex = 1'b1; v.st = 2'd0;
            m_mode = 0; m_left = 0; m_pend = 1'b0;
            return;
        end
        if (!v.ce) begin
            v.sall = 1'b1;
            return;
        end
`ifdef PIPELINE_CTRL_FORWARD_EN
        haz  = v.ex_ld && (hit(v.rs1, v.ex_rd, v.ex_we) || hit(v.rs2, v.ex_rd, v.ex_we));
        v.fa = fsel(hit(v.rs1, v.mem_rd, v.mem_we), hit(v.rs1, v.wb_rd, v.wb_we));
        v.fb = fsel(hit(v.rs2, v.mem_rd, v.mem_we), hit(v.rs2, v.wb_rd, v.wb_we));
`else
        haz = hit(v.rs1, v.ex_rd, v.ex_we) || hit(v.rs2, v.ex_rd, v.ex_we) ||
              hit(v.rs1, v.mem_rd, v.mem_we) || hit(v.rs2, v.mem_rd, v.mem_we) ||
              hit(v.rs1, v.wb_rd, v.wb_we) || hit(v.rs2, v.wb_rd, v.wb_we);
`endif
        if (m_mode == 0 || m_mode == 1) begin
            if (v.busy) begin
                m_mode = 3; m_pend = v.chg;
            end else if (v.chg) begin
                v.ffd = 1'b1; v.fex = 1'b1;
                m_left = FC - 1;
                m_mode = (m_left == 0) ? 0 : 2;
            end else if (haz) begin
                v.sfd = 1'b1; v.fex = 1'b1; m_mode = 1;
            end else begin
                m_mode = 0;
            end
        end else if (m_mode == 2) begin
            v.ffd = 1'b1; v.fex = 1'b1;
            if (v.busy) begin
                m_mode = 3; m_pend = 1'b1;
            end else begin
                m_left = v.chg ? FC - 1 : m_left - 1;
                m_mode = (m_left == 0) ? 0 : 2;
            end
        end else begin
            v.sall = 1'b1;
            m_pend = m_pend | v.chg;
            if (!v.busy) begin
                if (m_pend) begin
                    m_mode = 2; m_left = FC;
                end else begin
                    m_mode = 0;
                end
                m_pend = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then advance a clock.
    task automatic run_vec(input vec_t v, input string name);
        logic [9:0] got, want;
        rst = v.rst; ce = v.ce; chg = v.chg; busy = v.busy;
        rs1 = v.rs1; rs2 = v.rs2; ex_rd = v.ex_rd; ex_we = v.ex_we; ex_ld = v.ex_ld;
        mem_rd = v.mem_rd; mem_we = v.mem_we; wb_rd = v.wb_rd; wb_we = v.wb_we;
        #2;
        got  = {o_sfd, o_sall, o_ffd, o_fex, o_fa, o_fb, o_st};
        want = {v.sfd, v.sall, v.ffd, v.fex, v.fa, v.fb, v.st};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got sfd/sall/ffd/fex=%b%b%b%b fa=%0d fb=%0d st=%0d, want %b%b%b%b fa=%0d fb=%0d st=%0d",
                     name, o_sfd, o_sall, o_ffd, o_fex, o_fa, o_fb, o_st,
                     v.sfd, v.sall, v.ffd, v.fex, v.fa, v.fb, v.st);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t h;

    initial begin
        rst = 1'b1; ce = 1'b1; chg = 1'b0; busy = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0; ex_we = 1'b0; ex_ld = 1'b0;
        mem_rd = 5'd0; mem_we = 1'b0; wb_rd = 5'd0; wb_we = 1'b0;
        @(posedge clk);
        #1;

        // rst ce chg busy | sfd sall ffd fex state
        tbl.push_back(v_ctl(1,1,0,0, 0,0,1,1, 2'd0)); // reset outputs
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0)); // idle run
        tbl.push_back(v_ctl(0,1,1,0, 0,0,1,1, 2'd0)); // redirect cycle flushes
        tbl.push_back(v_ctl(0,1,0,0, 0,0,1,1, 2'd2)); // second flush cycle
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0)); // exactly two flush cycles
        tbl.push_back(v_ctl(0,1,0,1, 0,0,0,0, 2'd0)); // busy seen in run
        tbl.push_back(v_ctl(0,1,1,1, 0,1,0,0, 2'd3)); // redirect during wait
        tbl.push_back(v_ctl(0,1,0,1, 0,1,0,0, 2'd3));
        tbl.push_back(v_ctl(0,1,0,1, 0,1,0,0, 2'd3));
        tbl.push_back(v_ctl(0,1,0,0, 0,1,0,0, 2'd3)); // busy drops: still stalled
        tbl.push_back(v_ctl(0,1,0,0, 0,0,1,1, 2'd2)); // pending flush
        tbl.push_back(v_ctl(0,1,0,0, 0,0,1,1, 2'd2));
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0));
        tbl.push_back(v_ctl(0,0,1,0, 0,1,0,0, 2'd0)); // ce low ignores redirect
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0));
        tbl.push_back(v_ctl(0,1,1,0, 0,0,1,1, 2'd0)); // redirect
        tbl.push_back(v_ctl(1,1,0,0, 0,0,1,1, 2'd0)); // reset during flush
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0)); // no residual flush
        tbl.push_back(v_ctl(0,1,1,0, 0,0,1,1, 2'd0));
        tbl.push_back(v_ctl(0,1,1,0, 0,0,1,1, 2'd2)); // redirect in flush restarts
        tbl.push_back(v_ctl(0,1,0,0, 0,0,1,1, 2'd2));
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0));
        tbl.push_back(v_ctl(0,1,1,0, 0,0,1,1, 2'd0));
        tbl.push_back(v_ctl(0,1,0,1, 0,0,1,1, 2'd2)); // busy in flush
        tbl.push_back(v_ctl(0,1,0,0, 0,1,0,0, 2'd3));
        tbl.push_back(v_ctl(0,1,0,0, 0,0,1,1, 2'd2)); // flush not lost, full length
        tbl.push_back(v_ctl(0,1,0,0, 0,0,1,1, 2'd2));
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0));
        tbl.push_back(v_ctl(0,1,0,1, 0,0,0,0, 2'd0));
        tbl.push_back(v_ctl(0,0,0,0, 0,1,0,0, 2'd3)); // ce low freezes wait
        tbl.push_back(v_ctl(0,1,0,0, 0,1,0,0, 2'd3));
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0));
        tbl.push_back(v_ctl(0,1,0,1, 0,0,0,0, 2'd0));
        tbl.push_back(v_ctl(1,1,0,1, 0,0,1,1, 2'd0)); // reset during wait
        tbl.push_back(v_ctl(0,1,0,0, 0,0,0,0, 2'd0));
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

`ifdef PIPELINE_CTRL_FORWARD_EN
        h = v_ctl(0,1,0,0, 1,0,0,1, 2'd0);
        h.ex_rd = 5'd5; h.ex_we = 1'b1; h.ex_ld = 1'b1; h.rs1 = 5'd5;
        run_vec(h, "ld_use_stall");
        h = v_ctl(0,1,0,0, 0,0,0,0, 2'd1);
        h.mem_rd = 5'd5; h.mem_we = 1'b1; h.rs1 = 5'd5; h.fa = 2'd1;
        run_vec(h, "ld_use_release");
        run_vec(v_ctl(0,1,0,0, 0,0,0,0, 2'd0), "ld_use_run");
        h = v_ctl(0,1,0,0, 0,0,0,0, 2'd0);
        h.mem_rd = 5'd3; h.mem_we = 1'b1; h.wb_rd = 5'd3; h.wb_we = 1'b1; h.rs2 = 5'd3; h.fb = 2'd1;
        run_vec(h, "fwd_mem_over_wb");
        h = v_ctl(0,1,0,0, 0,0,0,0, 2'd0);
        h.wb_rd = 5'd6; h.wb_we = 1'b1; h.rs1 = 5'd6; h.fa = 2'd2;
        run_vec(h, "fwd_wb");
        h = v_ctl(0,1,0,0, 0,0,0,0, 2'd0);
        h.ex_rd = 5'd2; h.ex_we = 1'b1; h.rs1 = 5'd2;
        run_vec(h, "ex_alu_no_stall");
        h = v_ctl(0,1,0,0, 0,0,0,0, 2'd0);
        h.ex_rd = 5'd0; h.ex_we = 1'b1; h.ex_ld = 1'b1; h.mem_rd = 5'd0; h.mem_we = 1'b1;
        run_vec(h, "rd0_no_hazard");
`else
        h = v_ctl(0,1,0,0, 1,0,0,1, 2'd0);
        h.wb_rd = 5'd7; h.wb_we = 1'b1; h.rs1 = 5'd7;
        run_vec(h, "wb_haz1");
        h.st = 2'd1;
        run_vec(h, "wb_haz2");
        run_vec(h, "wb_haz3");
        h.rs1 = 5'd0; h.sfd = 1'b0; h.fex = 1'b0;
        run_vec(h, "wb_haz_clear");
        run_vec(v_ctl(0,1,0,0, 0,0,0,0, 2'd0), "wb_haz_run");
        h = v_ctl(0,1,0,0, 1,0,0,1, 2'd0);
        h.mem_rd = 5'd4; h.mem_we = 1'b1; h.rs2 = 5'd4;
        run_vec(h, "mem_haz_rs2");
        h = v_ctl(0,1,0,0, 0,0,0,0, 2'd1);
        run_vec(h, "mem_haz_clear");
        h = v_ctl(0,1,0,0, 0,0,0,0, 2'd0);
        h.ex_rd = 5'd0; h.ex_we = 1'b1; h.mem_rd = 5'd0; h.mem_we = 1'b1;
        run_vec(h, "rd0_no_hazard");
`endif
        h = v_ctl(0,1,1,0, 0,0,1,1, 2'd0);
        h.ex_rd = 5'd3; h.ex_we = 1'b1; h.ex_ld = 1'b1; h.rs1 = 5'd3;
        run_vec(h, "chg_beats_hazard");
        h.chg = 1'b0; h.st = 2'd2;
        run_vec(h, "flush_ignores_hazard");
        run_vec(v_ctl(0,1,0,0, 0,0,0,0, 2'd0), "after_flush");

        // Randomized stimulus against the model.
        h = v_ctl(1,1,0,0, 0,0,0,0, 2'd0);
        model(h);
        run_vec(h, "rand_reset");
        for (int n = 0; n < 3000; n++) begin
            h.rst    = ($urandom_range(0, 99) < 2);
            h.ce     = ($urandom_range(0, 99) < 90);
            h.chg    = ($urandom_range(0, 99) < 12);
            h.busy   = ($urandom_range(0, 99) < 20);
            h.rs1    = 5'($urandom_range(0, 3));
            h.rs2    = 5'($urandom_range(0, 3));
            h.ex_rd  = 5'($urandom_range(0, 3));
            h.ex_we  = 1'($urandom_range(0, 1));
            h.ex_ld  = 1'($urandom_range(0, 1));
            h.mem_rd = 5'($urandom_range(0, 3));
            h.mem_we = 1'($urandom_range(0, 1));
            h.wb_rd  = 5'($urandom_range(0, 3));
            h.wb_we  = 1'($urandom_range(0, 1));
            model(h);
            run_vec(h, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, register-address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, flush length after a taken branch/jump (range 1..7).
REQ-003 SHALL have ports: pc_clk  in  1  single clock; pc_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: pc_i_ce  in  1  global enable; pc_i_rs1_addr / pc_i_rs2_addr  in  AWIDTH  decode-stage source registers.
REQ-005 SHALL have ports: pc_i_ex_rd_addr  in  AWIDTH, pc_i_ex_rd_we  in  1, pc_i_ex_is_load  in  1  (execute stage); pc_i_mem_rd_addr  in  AWIDTH, pc_i_mem_rd_we  in  1 (memory stage); pc_i_wb_rd_addr  in  AWIDTH, pc_i_wb_rd_we  in  1 (writeback stage).
REQ-006 SHALL have ports: pc_i_change_pc  in  1  taken branch/jump from execute; pc_i_mem_busy  in  1  data memory not ready.
REQ-007 SHALL have outputs: pc_o_stall_fd  1  hold fetch+decode; pc_o_stall_all  1  hold every stage; pc_o_flush_fd  1  squash fetch+decode; pc_o_flush_ex  1  inject bubble into execute; pc_o_fwd_a / pc_o_fwd_b  2  operand forward select (0 regfile, 1 mem, 2 wb); pc_o_state  2  FSM state code.

Function
REQ-008 SHALL implement FSM states RUN=0, HSTALL=1, FLUSH=2, MWAIT=3, held in one register.
REQ-009 SHALL treat a hazard as source address equal to a stage rd_addr with that stage's rd_we=1; rd_addr 0 SHALL never match.
REQ-010 SHALL evaluate event priority each enabled cycle: mem_busy > change_pc > hazard.
REQ-011 RUN: stall/flush outputs 0; mem_busy -> MWAIT; change_pc -> FLUSH with counter loaded FLUSH_CYCLES-1; hazard -> HSTALL.
REQ-012 Hazard cycle (RUN or HSTALL): pc_o_stall_fd=1 and pc_o_flush_ex=1 combinationally in the same cycle.
REQ-013 HSTALL: returns to RUN in the first cycle with no hazard, no busy and no change_pc; change_pc or mem_busy take the REQ-011 transitions.
REQ-014 FLUSH: pc_o_flush_fd=1 and pc_o_flush_ex=1 every cycle; hazards ignored; counter decrements; at count 0 -> RUN; total flush = FLUSH_CYCLES cycles including the change_pc cycle.
REQ-015 A change_pc arriving in FLUSH SHALL reload the counter (flush restarts).
REQ-016 MWAIT: pc_o_stall_all=1, all other stall/flush 0; change_pc seen here SHALL set a pending flag; on busy deassert -> FLUSH if pending (flag cleared) else RUN.
REQ-017 mem_busy during FLUSH SHALL go to MWAIT with pending=1 (flush not lost).
REQ-018 pc_i_ce=0 SHALL freeze state, counter and pending; outputs: pc_o_stall_all=1, others 0.
REQ-019 Stall/flush/forward outputs SHALL be combinational from state and current inputs; no output SHALL depend combinationally on itself.

Reset
REQ-020 On pc_rst=1 at a clock edge: state=RUN, counter=0, pending=0.
REQ-021 While pc_rst=1: pc_o_flush_fd=1, pc_o_flush_ex=1, pc_o_stall_fd=0, pc_o_stall_all=0, fwd=0, pc_o_state=0.
REQ-022 Reset asserted mid-FLUSH or mid-MWAIT SHALL abandon the operation; first post-reset cycle is RUN.

Configuration
REQ-023 Macro PIPELINE_CTRL_FORWARD_EN defined: only ex-stage load matches (pc_i_ex_is_load=1) are hazards, giving exactly one HSTALL cycle; fwd_a/fwd_b select mem (1) over wb (2) on match, else 0.
REQ-024 Macro undefined: any ex, mem or wb match is a hazard; HSTALL persists until all matches clear; fwd_a/fwd_b tied 0.

Structure
REQ-025 State codes, forward-select codes and FLUSH_CYCLES default SHALL live in a shared include/package, guarded against double inclusion.
REQ-026 One sub-module, hazard_detect (combinational source/rd comparison, forward select), is natural; FSM stays in pipeline_ctrl.

Verification
REQ-027 Forward on: ex load rd=5, rs1=5 -> stall_fd=1, flush_ex=1 one cycle, state 1 then 0.
REQ-028 Forward on: mem rd=3 we=1, wb rd=3 we=1, rs2=3 -> fwd_b=1, no stall; rd=0 with rs1=0 -> no hazard, fwd_a=0.
REQ-029 Forward off: wb rd=7 we=1, rs1=7 held 3 cycles -> stall_fd=1 for 3 cycles, then RUN.
REQ-030 change_pc pulse, FLUSH_CYCLES=2 -> flush_fd=flush_ex=1 for exactly 2 cycles; change_pc+hazard same cycle -> FLUSH wins.
REQ-031 mem_busy 4 cycles with change_pc in cycle 2 -> stall_all=1 for 4 cycles, then 2 flush cycles.
REQ-032 pc_rst asserted during FLUSH cycle 1 -> flush outputs 1 during reset, state 0 afterwards, no residual flush.
